// File: rtl/vga_scene_renderer.sv
// VGA scene renderer: parametrised sync generation plus paddle, ball and
// brick-grid rendering. Sprite positions are captured once per frame and the
// pixel path is a fixed two-stage pipeline behind the stage-0 counters.
module vga_scene_renderer #(
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int ROWS      = 2,
    parameter int COLS      = 5,
    parameter int BLK_X0    = 40,
    parameter int BLK_Y0    = 40,
    parameter int BLK_W     = 80,
    parameter int BLK_H     = 30,
    parameter int PITCH_X   = 120,
    parameter int PITCH_Y   = 50,
    parameter int BALL_SIZE = 8,
    parameter int PAD_Y     = 440,
    parameter int PAD_H     = 10,
    parameter int PAD_W     = 100,
    parameter int AW        = $clog2(ROWS * COLS)
) (
    input  logic          CLK_25MH,
    input  logic          reset_n,
    input  logic [9:0]    paddle_pos,
    input  logic [9:0]    ball_x,
    input  logic [9:0]    ball_y,
    input  logic          blk_we,
    input  logic [AW-1:0] blk_waddr,
    input  logic [1:0]    blk_wdata,
    input  logic [AW-1:0] blk_raddr,
    output logic [1:0]    blk_rdata,
    output logic          frame_start,
    output logic [9:0]    hor_count,
    output logic [9:0]    ver_count,
    output logic          hsync,
    output logic          vsync,
    output logic [5:0]    RGB
);

    localparam int          H_TOT  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int          V_TOT  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int          HS_BEG = H_ACTIVE + H_FP;
    localparam int          VS_BEG = V_ACTIVE + V_FP;
    localparam int unsigned NB     = ROWS * COLS;

    logic [9:0]    hcount_q, vcount_q;
    logic [9:0]    snap_pad_q, snap_bx_q, snap_by_q;
    logic [1:0]    health_q [NB];
    logic [1:0]    rdata_q;
    logic          fs;

    // Stage-0 derived values
    logic [10:0]   hx, vy;
    logic          blank_s0, pad_s0, ball_s0, hs_s0, vs_s0;
    logic          brick_s0, odd_s0;
    logic [AW-1:0] idx_s0;
    logic [COLS-1:0] col_hit;
    logic [ROWS-1:0] row_hit;

    // Stage-1 registers
    logic          blank_q, pad_q, ball_q, brick_q, odd_q, hs1_q, vs1_q;
    logic [AW-1:0] idx_q;

    // Stage-2 registers
    logic [5:0]    rgb_q, rgb_d;
    logic          hs_q, vs_q;
    logic [1:0]    hlth;

    assign fs = (hcount_q == 10'd0) && (vcount_q == 10'(V_ACTIVE));
    assign hx = {1'b0, hcount_q};
    assign vy = {1'b0, vcount_q};

    // Horizontal/vertical raster counters
    always_ff @(posedge CLK_25MH or negedge reset_n) begin
        if (!reset_n) begin
            hcount_q <= '0;
            vcount_q <= '0;
        end else if (hcount_q == 10'(H_TOT - 1)) begin
            hcount_q <= '0;
            vcount_q <= (vcount_q == 10'(V_TOT - 1)) ? '0 : vcount_q + 10'd1;
        end else begin
            hcount_q <= hcount_q + 10'd1;
        end
    end

    // Capture sprite positions once per frame at entry to vertical blank
    always_ff @(posedge CLK_25MH or negedge reset_n) begin
        if (!reset_n) begin
            snap_pad_q <= '0;
            snap_bx_q  <= '0;
            snap_by_q  <= '0;
        end else if (fs) begin
            snap_pad_q <= paddle_pos;
            snap_bx_q  <= ball_x;
            snap_by_q  <= ball_y;
        end
    end

    // Stage-0 sync and sprite hit tests, all in 11 bits so sums cannot wrap
    always_comb begin
        blank_s0 = (hcount_q >= 10'(H_ACTIVE)) || (vcount_q >= 10'(V_ACTIVE));
        hs_s0    = !((hx >= 11'(HS_BEG)) && (hx < 11'(HS_BEG + H_SYNC)));
        vs_s0    = !((vy >= 11'(VS_BEG)) && (vy < 11'(VS_BEG + V_SYNC)));
        pad_s0   = (hx >= {1'b0, snap_pad_q}) && (hx < {1'b0, snap_pad_q} + 11'(PAD_W))
                && (vy >= 11'(PAD_Y)) && (vy < 11'(PAD_Y + PAD_H));
        ball_s0  = (hx >= {1'b0, snap_bx_q}) && (hx < {1'b0, snap_bx_q} + 11'(BALL_SIZE))
                && (vy >= {1'b0, snap_by_q}) && (vy < {1'b0, snap_by_q} + 11'(BALL_SIZE));
    end

    // Brick column/row bands are fixed at elaboration, so only comparators remain
    for (genvar c = 0; c < COLS; c++) begin : g_col
        localparam int X0 = BLK_X0 + c * PITCH_X;
        assign col_hit[c] = (hx >= 11'(X0)) && (hx < 11'(X0 + BLK_W));
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        localparam int Y0 = BLK_Y0 + r * PITCH_Y;
        assign row_hit[r] = (vy >= 11'(Y0)) && (vy < 11'(Y0 + BLK_H));
    end

    // Encode the single brick under the beam (bricks never overlap)
    always_comb begin
        brick_s0 = 1'b0;
        idx_s0   = '0;
        odd_s0   = 1'b0;
        for (int unsigned r = 0; r < ROWS; r++) begin
            for (int unsigned c = 0; c < COLS; c++) begin
                if (row_hit[r] && col_hit[c]) begin
                    brick_s0 = 1'b1;
                    idx_s0   = AW'(r * COLS + c);
                    odd_s0   = r[0];
                end
            end
        end
    end

    // Stage 1: register hit flags, brick index/row parity and raw syncs
    always_ff @(posedge CLK_25MH or negedge reset_n) begin
        if (!reset_n) begin
            blank_q <= 1'b0;
            pad_q   <= 1'b0;
            ball_q  <= 1'b0;
            brick_q <= 1'b0;
            odd_q   <= 1'b0;
            idx_q   <= '0;
            hs1_q   <= 1'b1;
            vs1_q   <= 1'b1;
        end else begin
            blank_q <= blank_s0;
            pad_q   <= pad_s0;
            ball_q  <= ball_s0;
            brick_q <= brick_s0;
            odd_q   <= odd_s0;
            idx_q   <= idx_s0;
            hs1_q   <= hs_s0;
            vs1_q   <= vs_s0;
        end
    end

    assign hlth = health_q[idx_q];

    // Pixel colour by priority: blank, paddle, ball, live brick, background
    always_comb begin
        rgb_d = '0;
        if (blank_q) begin
            rgb_d = '0;
        end else if (pad_q) begin
            rgb_d = 6'b100001;
        end else if (ball_q) begin
            rgb_d = 6'b111100;
        end else if (brick_q && (hlth != 2'd0)) begin
            rgb_d = odd_q ? {2'b00, hlth, 2'b00} : {4'b0000, hlth};
        end
    end

    // Stage 2: register colour and syncs so they stay aligned
    always_ff @(posedge CLK_25MH or negedge reset_n) begin
        if (!reset_n) begin
            rgb_q <= '0;
            hs_q  <= 1'b1;
            vs_q  <= 1'b1;
        end else begin
            rgb_q <= rgb_d;
            hs_q  <= hs1_q;
            vs_q  <= vs1_q;
        end
    end

    // Brick health store: guarded write, registered read-before-write
    always_ff @(posedge CLK_25MH or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < NB; i++) begin
                health_q[i] <= 2'd3;
            end
            rdata_q <= '0;
        end else begin
            if (blk_we && (32'(blk_waddr) < NB)) begin
                health_q[blk_waddr] <= blk_wdata;
            end
            rdata_q <= (32'(blk_raddr) < NB) ? health_q[blk_raddr] : 2'd0;
        end
    end

    assign blk_rdata   = rdata_q;
    assign frame_start = fs;
    assign hor_count   = hcount_q;
    assign ver_count   = vcount_q;
    assign hsync       = hs_q;
    assign vsync       = vs_q;
    assign RGB         = rgb_q;

endmodule

// File: tb/tb_vga_scene_renderer.sv
// Scoreboard bench for vga_scene_renderer on a reduced raster so several
// frames fit in a short run. Expected pixels and read data are queued by the
// stimulus; a monitor pops and compares them as the DUT presents them.
module tb_vga_scene_renderer;

    localparam int HA = 224, HFP = 4, HSY = 16, HBP = 12;
    localparam int HT = HA + HFP + HSY + HBP;          // 256
    localparam int VA = 100, VFP = 2, VSY = 2, VBP = 2;
    localparam int VT = VA + VFP + VSY + VBP;          // 106
    localparam int FRAME = HT * VT;                    // 27136

    logic       clk = 1'b0;
    logic       reset_n;
    logic [9:0] paddle_pos, ball_x, ball_y;
    logic       blk_we;
    logic [3:0] blk_waddr, blk_raddr;
    logic [1:0] blk_wdata, blk_rdata;
    logic       frame_start, hsync, vsync;
    logic [9:0] hor_count, ver_count;
    logic [5:0] RGB;

    logic rd_issue = 1'b0;
    logic rd_seen  = 1'b0;

    typedef struct {
        int         x;
        int         y;
        logic [5:0] rgb;
    } pix_t;

    pix_t       pq[$];
    logic [1:0] rq[$];

    int pass_cnt = 0;
    int total_cnt = 0;
    int fs_count = 0;

    vga_scene_renderer #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
        .PAD_Y(92), .PAD_H(6), .PAD_W(100)
    ) dut (
        .CLK_25MH   (clk),
        .reset_n    (reset_n),
        .paddle_pos (paddle_pos),
        .ball_x     (ball_x),
        .ball_y     (ball_y),
        .blk_we     (blk_we),
        .blk_waddr  (blk_waddr),
        .blk_wdata  (blk_wdata),
        .blk_raddr  (blk_raddr),
        .blk_rdata  (blk_rdata),
        .frame_start(frame_start),
        .hor_count  (hor_count),
        .ver_count  (ver_count),
        .hsync      (hsync),
        .vsync      (vsync),
        .RGB        (RGB)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rd_seen <= rd_issue;

    task automatic check(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic summary();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    endtask

    task automatic exp_pix(input int x, input int y, input logic [5:0] rgb);
        pix_t p;
        p.x = x; p.y = y; p.rgb = rgb;
        pq.push_back(p);
    endtask

    task automatic wait_fs(input string what);
        int n = 0;
        do begin @(negedge clk); n++; end while (!frame_start && n < 2 * FRAME);
        if (!frame_start) begin
            total_cnt++;
            $display("FAIL %s: no frame_start within %0d cycles", what, 2 * FRAME);
            summary();
        end
    endtask

    task automatic wait_line(input int v);
        int n = 0;
        do begin @(negedge clk); n++; end
        while (!(ver_count == 10'(v) && hor_count == 10'd0) && n < 2 * FRAME);
        if (!(ver_count == 10'(v) && hor_count == 10'd0)) begin
            total_cnt++;
            $display("FAIL wait_line%0d: line not reached within %0d cycles", v, 2 * FRAME);
            summary();
        end
    endtask

    task automatic rd(input int addr, input logic [1:0] exp);
        @(posedge clk); #1;
        blk_we    = 1'b0;
        blk_raddr = 4'(addr);
        rd_issue  = 1'b1;
        rq.push_back(exp);
    endtask

    // Monitor: pixel scoreboard, read data, sync and frame timing
    initial begin
        int hd1 = 0, hd2 = 0, vd1 = 0, vd2 = 0;
        int cyc = 0, last_fs = 0, vs_low = 0, hs_run = 0;
        logic prev_hs = 1'b1, prev_vs = 1'b1;
        pix_t p;
        forever begin
            @(negedge clk);
            if (!reset_n) continue;
            cyc++;
            if (pq.size() > 0 && pq[0].x == hd2 && pq[0].y == vd2) begin
                p = pq.pop_front();
                check($sformatf("pix(%0d,%0d)", p.x, p.y), int'(RGB), int'(p.rgb));
            end
            hd2 = hd1; hd1 = int'(hor_count);
            vd2 = vd1; vd1 = int'(ver_count);
            if (rd_seen) begin
                if (rq.size() == 0) check("rd_unexpected", 1, 0);
                else check("blk_rdata", int'(blk_rdata), int'(rq.pop_front()));
            end
            if (prev_hs && !hsync) begin
                check("hsync_fall_hor", int'(hor_count), HA + HFP + 2);
                hs_run = 0;
            end
            if (!prev_hs && hsync) check("hsync_low_len", hs_run, HSY);
            if (!hsync) hs_run++;
            if (prev_vs && !vsync) begin
                check("vsync_fall_ver", int'(ver_count), VA + VFP);
                check("vsync_fall_hor", int'(hor_count), 2);
            end
            if (!vsync) vs_low++;
            prev_hs = hsync;
            prev_vs = vsync;
            if (frame_start) begin
                fs_count++;
                check("fs_ver", int'(ver_count), VA);
                check("fs_hor", int'(hor_count), 0);
                if (fs_count > 1) begin
                    check("fs_period", cyc - last_fs, FRAME);
                    check("vsync_low_clks", vs_low, VSY * HT);
                end
                last_fs = cyc;
                vs_low  = 0;
            end
        end
    end

    initial begin
        #(85000 * 10);
        total_cnt++;
        $display("FAIL watchdog: run exceeded %0d cycles", 85000);
        summary();
    end

    initial begin
        reset_n = 1'b0;
        paddle_pos = '0; ball_x = '0; ball_y = '0;
        blk_we = 1'b0; blk_waddr = '0; blk_wdata = '0; blk_raddr = '0;

        // Frame A renders with reset snapshots: ball (0,0), paddle x=0
        exp_pix(3, 3, 6'b111100);
        exp_pix(8, 3, 6'b000000);
        exp_pix(40, 40, 6'b000011);
        exp_pix(119, 40, 6'b000011);
        exp_pix(120, 40, 6'b000000);
        exp_pix(223, 40, 6'b000011);
        exp_pix(224, 40, 6'b000000);
        exp_pix(40, 90, 6'b001100);
        exp_pix(50, 94, 6'b100001);
        exp_pix(99, 94, 6'b100001);
        exp_pix(100, 94, 6'b001100);
        exp_pix(40, 99, 6'b001100);
        exp_pix(40, 100, 6'b000000);

        repeat (3) @(negedge clk);
        check("rst_rgb", int'(RGB), 0);
        check("rst_hsync", int'(hsync), 1);
        check("rst_vsync", int'(vsync), 1);
        check("rst_frame_start", int'(frame_start), 0);
        check("rst_hor", int'(hor_count), 0);
        check("rst_ver", int'(ver_count), 0);
        check("rst_rdata", int'(blk_rdata), 0);

        @(posedge clk); #1;
        reset_n = 1'b1;
        paddle_pos = 10'd30; ball_x = 10'd100; ball_y = 10'd45;

        for (int i = 0; i < 10; i++) rd(i, 2'd3);
        @(posedge clk); #1 rd_issue = 1'b0;

        wait_fs("fs1");
        // Frame B: ball (100,45), paddle x=30
        exp_pix(100, 45, 6'b111100);
        exp_pix(108, 45, 6'b000011);
        exp_pix(170, 45, 6'b000011);
        exp_pix(107, 52, 6'b111100);
        exp_pix(100, 53, 6'b000011);
        exp_pix(29, 94, 6'b000000);
        exp_pix(30, 94, 6'b100001);
        exp_pix(40, 94, 6'b100001);
        exp_pix(129, 94, 6'b100001);
        exp_pix(130, 94, 6'b000000);

        wait_line(20);
        @(posedge clk); #1 ball_x = 10'd170;

        wait_fs("fs2");
        @(posedge clk); #1;
        blk_we = 1'b1; blk_waddr = 4'd0; blk_wdata = 2'd0;
        blk_raddr = 4'd0; rd_issue = 1'b1; rq.push_back(2'd3);
        rd(0, 2'd0);
        @(posedge clk); #1;
        blk_we = 1'b1; blk_waddr = 4'd12; blk_wdata = 2'd1; rd_issue = 1'b0;
        for (int i = 0; i < 10; i++) rd(i, (i == 0) ? 2'd0 : 2'd3);
        @(posedge clk); #1 rd_issue = 1'b0;

        // Frame C: ball moved to x=170, brick 0 destroyed
        exp_pix(40, 40, 6'b000000);
        exp_pix(100, 45, 6'b000000);
        exp_pix(169, 45, 6'b000011);
        exp_pix(170, 45, 6'b111100);
        exp_pix(177, 45, 6'b111100);
        exp_pix(178, 45, 6'b000011);

        wait_line(0);
        wait_line(50);
        repeat (4) @(negedge clk);
        check("pix_queue_left", pq.size(), 0);
        check("rd_queue_left", rq.size(), 0);
        check("fs_count", fs_count, 2);
        summary();
    end

endmodule

// File: doc/vga_scene_renderer.md
Name: vga_scene_renderer

Overview:
Parametrised successor to the Breakout VGA block. It generates VGA timing from configurable porch and sync parameters and renders paddle, ball and an R x C brick grid. Each brick holds 2-bit health, written and read back by game logic. Sprite inputs are snapshotted once per frame so frames never tear, and RGB/sync leave through a fixed 2-stage pipeline.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal front porch / sync / back porch (clocks)
V_ACTIVE, 480, visible lines
V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical front porch / sync / back porch (lines)
ROWS, 2, brick rows
COLS, 5, brick columns
BLK_X0 / BLK_Y0, 40 / 40, top-left pixel of brick (0,0)
BLK_W / BLK_H, 80 / 30, brick size in pixels
PITCH_X / PITCH_Y, 120 / 50, brick-to-brick stride
BALL_SIZE, 8, ball edge length in pixels
PAD_Y / PAD_H / PAD_W, 440 / 10 / 100, paddle top line / height / width
AW, clog2(ROWS*COLS), brick address width (derived)

Ports:
CLK_25MH  in  1  pixel clock
reset_n  in  1  asynchronous, active-low reset
paddle_pos  in  10  paddle left x
ball_x  in  10  ball left x
ball_y  in  10  ball top y
blk_we  in  1  brick health write strobe
blk_waddr  in  AW  brick index written (row*COLS+col)
blk_wdata  in  2  new health (0 = destroyed)
blk_raddr  in  AW  brick index read
blk_rdata  out  2  health at blk_raddr (1-cycle latency)
frame_start  out  1  one-cycle pulse on entry to vertical blank
hor_count  out  10  stage-0 horizontal counter
ver_count  out  10  stage-0 vertical counter
hsync  out  1  active-low horizontal sync, pipeline-aligned
vsync  out  1  active-low vertical sync, pipeline-aligned
RGB  out  6  RRGGBB pixel, pipeline-aligned

Behaviour:
- Clock is CLK_25MH. reset_n is asynchronous and active-low.
- Reset values: hcount=0, vcount=0, hsync=1, vsync=1, RGB=0, frame_start=0, blk_rdata=0, snapshot registers=0, pipeline registers=0. Every brick health resets to 3.
- Counters: hcount wraps at H_TOT-1 = H_ACTIVE+H_FP+H_SYNC+H_BP-1 (799). vcount increments when hcount wraps and itself wraps at V_TOT-1 (524).
- Sync (stage 0): hsync_raw=0 for hcount in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), i.e. [656,752). vsync_raw=0 for vcount in [490,492).
- Pipeline: stage 1 registers hit flags and brick index/row. Stage 2 registers RGB, hsync and vsync. Output latency is exactly 2 clocks after hor_count/ver_count.
- frame_start=1 for the single cycle in which hcount==0 && vcount==V_ACTIVE. In that same cycle paddle_pos, ball_x and ball_y load into the snapshot registers. Rendering uses only the snapshots.
- Hit regions are half-open and all sums are computed in 11 bits, so there is no wrap:
  - ball: x in [bx, bx+BALL_SIZE), y in [by, by+BALL_SIZE)
  - paddle: x in [pp, pp+PAD_W), y in [PAD_Y, PAD_Y+PAD_H)
  - brick (r,c): x in [BLK_X0+c*PITCH_X, +BLK_W), y in [BLK_Y0+r*PITCH_Y, +BLK_H), drawn only when health!=0
- Brick geometry is elaboration-time constant. No runtime multipliers.
- RGB priority: blanking (hcount>=H_ACTIVE or vcount>=V_ACTIVE) gives 0, then paddle 6'b100001, then ball 6'b111100, then brick, then background 0.
- Brick colour: even row {4'b0000, health}; odd row {2'b00, health, 2'b00}.
- Write port: the write takes effect on the next clock edge. A blk_waddr >= ROWS*COLS is ignored. A write landing mid-frame may change rendering on the following pixel; that is acceptable.
- Read port: blk_rdata is registered. When the read and write hit the same address in the same cycle, blk_rdata returns the pre-write value.
- Reset asserted mid-frame: all state returns to reset values immediately. Counting resumes from 0,0 on the first clock after release.

Test Plan:
- Reset: hold reset_n=0 -> RGB=0, hsync=vsync=1, frame_start=0. After release, blk_rdata for every index reads 3.
- Timing: run 2 frames -> hsync low exactly 96 clocks per line, with first low output at hor_count==658. vsync low 2 lines per 525. frame_start pulses once per 420000 clocks.
- Snapshot: change ball_x from 100 to 300 mid-frame at line 200 -> ball still drawn at x=100 until after the next frame_start, then drawn at x=300.
- Brick render: at ver_count=40, hor_count=40 -> RGB=6'b000011 two clocks later. At hor_count=119 still 6'b000011. At 120 RGB=0. Brick 5 at (40,90) -> 6'b001100.
- Health write/read: blk_we=1, waddr=0, wdata=0 with raddr=0 in the same cycle -> blk_rdata=3 next clock, then 0. Brick 0 no longer drawn. waddr=12 is ignored.
- Priority: ball at (40,40) over brick 0, paddle_pos=30 at y=440 -> pixel (42,42)=6'b111100, pixel (40,445)=6'b100001.
